// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch squash,
// data-memory freeze, plus saturating stall / flush performance counters.
module hazard_ctrl #(
  parameter int ASIZE        = 5,
  parameter int BR_FLUSH_CYC = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] LP_BR_LOAD  = 4'(BR_FLUSH_CYC - 1);
  localparam bit         LP_BR_MULTI = (BR_FLUSH_CYC > 1);
  localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_dcnt;
  logic [3:0]       w_dcnt_next;
  logic [CNT_W-1:0] r_cnt [2];

  logic w_memstall;
  logic w_loaduse;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_run_eval;
  logic w_ms_eff;
  logic w_pcw;
  logic w_ifw;
  logic w_iff;
  logic w_bub;
  logic w_idf;
  logic w_frz;
  logic w_flush_ev;
  logic [1:0] w_cnt_inc;

  assign w_memstall = mem_req & ~mem_ready;
  assign w_rs_hit   = id_use_rs & (id_rs == ex_waddr);
  assign w_rt_hit   = id_use_rt & (id_rt == ex_waddr);
  assign w_loaduse  = ex_memread & ex_wen & (ex_waddr != '0) & (w_rs_hit | w_rt_hit);

  always_comb begin
    w_pcw        = 1'b1;
    w_ifw        = 1'b1;
    w_iff        = 1'b0;
    w_bub        = 1'b0;
    w_idf        = 1'b0;
    w_frz        = 1'b0;
    w_flush_ev   = 1'b0;
    w_run_eval   = 1'b0;
    w_ms_eff     = 1'b0;
    w_state_next = r_state;
    w_dcnt_next  = r_dcnt;

    case (r_state)
      ST_RUN: begin
        w_run_eval = 1'b1;
        w_ms_eff   = w_memstall;
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          w_frz = 1'b1;
          w_pcw = 1'b0;
          w_ifw = 1'b0;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      ST_BR_FLUSH: begin
        if (w_memstall) begin
          w_frz = 1'b1;
          w_pcw = 1'b0;
          w_ifw = 1'b0;
        end else begin
          w_iff       = 1'b1;
          w_dcnt_next = r_dcnt - 4'd1;
          if (r_dcnt == 4'd1) w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase

    // Shared RUN priority chain; MEM_WAIT release enters here with memstall masked.
    if (w_run_eval) begin
      w_state_next = ST_RUN;
      if (w_ms_eff) begin
        w_frz        = 1'b1;
        w_pcw        = 1'b0;
        w_ifw        = 1'b0;
        w_state_next = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
        w_iff      = 1'b1;
        w_idf      = 1'b1;
        w_flush_ev = 1'b1;
        if (LP_BR_MULTI) begin
          w_dcnt_next  = LP_BR_LOAD;
          w_state_next = ST_BR_FLUSH;
        end
      end else if (w_loaduse) begin
        w_pcw = 1'b0;
        w_ifw = 1'b0;
        w_bub = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_dcnt  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  assign w_cnt_inc = {w_flush_ev, ~w_pcw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt_clr)
          r_cnt[i] <= '0;
        else if (w_cnt_inc[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + LP_ONE;
      end
    end
  end

  // Controls read as inactive (including the load enables) while reset is held.
  assign pc_write    = rst & w_pcw;
  assign ifid_write  = rst & w_ifw;
  assign ifid_flush  = rst & w_iff;
  assign idex_bubble = rst & w_bub;
  assign idex_flush  = rst & w_idf;
  assign pipe_freeze = rst & w_frz;
  assign state       = r_state;
  assign stall_cnt   = r_cnt[0];
  assign flush_cnt   = r_cnt[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl, plus hand sequences for
// asynchronous reset, counter saturation and the single-cycle flush build.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_waddr;
  logic       id_use_rs, id_use_rt, ex_memread, ex_wen, ex_branch_taken;
  logic       mem_req, mem_ready, cnt_clr;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;

  logic       s_br, s_mreq, s_mrdy, s_clr;
  logic       s_pcw, s_ifw, s_iff, s_bub, s_idf, s_frz;
  logic [1:0] s_state;
  logic [1:0] s_scnt, s_fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.ASIZE(5), .BR_FLUSH_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .cnt_clr(cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.ASIZE(5), .BR_FLUSH_CYC(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .id_rs(5'd0), .id_rt(5'd0), .id_use_rs(1'b0), .id_use_rt(1'b0),
    .ex_memread(1'b0), .ex_wen(1'b0), .ex_waddr(5'd0),
    .ex_branch_taken(s_br), .mem_req(s_mreq), .mem_ready(s_mrdy),
    .cnt_clr(s_clr),
    .pc_write(s_pcw), .ifid_write(s_ifw), .ifid_flush(s_iff),
    .idex_bubble(s_bub), .idex_flush(s_idf), .pipe_freeze(s_frz),
    .state(s_state), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic        urs, urt, mrd, wen;
    logic [4:0]  wa;
    logic        br, mreq, mrdy, clr;
    logic [5:0]  exp_o;   // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze}
    logic [1:0]  st;
    logic [15:0] sc, fc;
  } vec_t;

  localparam int NV = 34;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic urs, urt, mrd, wen,
                              input logic [4:0] wa, input logic br, mreq, mrdy, clr,
                              input logic [5:0] eo, input logic [1:0] st,
                              input logic [15:0] sc, fc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.wen = wen;
    v.wa = wa; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.clr = clr;
    v.exp_o = eo; v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_memread = 0; ex_wen = 0; ex_waddr = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs rt urs urt mrd wen wa br mreq mrdy clr exp st sc fc
    tv[0]  = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 0, 0);
    tv[1]  = mk(5,0,1,0,1,1,5, 0,0,0,0, 6'b000100, 0, 0, 0);
    tv[2]  = mk(5,0,1,0,0,1,5, 0,0,0,0, 6'b110000, 0, 1, 0);
    tv[3]  = mk(0,0,1,0,1,1,0, 0,0,0,0, 6'b110000, 0, 1, 0);
    tv[4]  = mk(5,0,0,0,1,1,5, 0,0,0,0, 6'b110000, 0, 1, 0);
    tv[5]  = mk(0,7,0,1,1,1,7, 0,0,0,0, 6'b000100, 0, 1, 0);
    tv[6]  = mk(0,7,0,1,1,0,7, 0,0,0,0, 6'b110000, 0, 2, 0);
    tv[7]  = mk(0,0,0,0,0,0,0, 1,0,0,0, 6'b111010, 0, 2, 0);
    tv[8]  = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b111000, 2, 2, 1);
    tv[9]  = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 2, 1);
    tv[10] = mk(5,0,1,0,1,1,5, 1,0,0,0, 6'b111010, 0, 2, 1);
    tv[11] = mk(5,0,1,0,1,1,5, 1,0,0,0, 6'b111000, 2, 2, 2);
    tv[12] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 2, 2);
    tv[13] = mk(0,0,0,0,0,0,0, 0,1,0,0, 6'b000001, 0, 2, 2);
    tv[14] = mk(0,0,0,0,0,0,0, 0,1,0,0, 6'b000001, 1, 3, 2);
    tv[15] = mk(0,0,0,0,0,0,0, 0,1,0,0, 6'b000001, 1, 4, 2);
    tv[16] = mk(0,0,0,0,0,0,0, 0,1,1,0, 6'b110000, 1, 5, 2);
    tv[17] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 5, 2);
    tv[18] = mk(0,0,0,0,0,0,0, 1,1,0,0, 6'b000001, 0, 5, 2);
    tv[19] = mk(0,0,0,0,0,0,0, 1,1,0,0, 6'b000001, 1, 6, 2);
    tv[20] = mk(0,0,0,0,0,0,0, 1,1,1,0, 6'b111010, 1, 7, 2);
    tv[21] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b111000, 2, 7, 3);
    tv[22] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 7, 3);
    tv[23] = mk(0,0,0,0,0,0,0, 0,1,0,1, 6'b000001, 0, 7, 3);
    tv[24] = mk(0,0,0,0,0,0,0, 0,0,1,0, 6'b110000, 1, 0, 0);
    tv[25] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 0, 0);
    tv[26] = mk(0,0,0,0,0,0,0, 1,0,0,0, 6'b111010, 0, 0, 0);
    tv[27] = mk(0,0,0,0,0,0,0, 0,1,0,0, 6'b000001, 2, 0, 1);
    tv[28] = mk(0,0,0,0,0,0,0, 0,1,0,0, 6'b000001, 2, 1, 1);
    tv[29] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b111000, 2, 2, 1);
    tv[30] = mk(0,0,0,0,0,0,0, 0,0,0,0, 6'b110000, 0, 2, 1);
    tv[31] = mk(5,0,1,0,1,1,5, 0,1,0,0, 6'b000001, 0, 2, 1);
    tv[32] = mk(5,0,1,0,1,1,5, 0,1,1,0, 6'b000100, 1, 3, 1);
    tv[33] = mk(5,0,1,0,0,1,5, 0,0,0,0, 6'b110000, 0, 4, 1);

    rst = 1'b0;
    idle_inputs();
    s_br = 0; s_mreq = 0; s_mrdy = 0; s_clr = 0;
    #3;
    chk("rst_outs", 0, {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze}, 32'd0);
    chk("rst_state", 0, {30'd0, state}, 32'd0);
    chk("rst_cnts", 0, {stall_cnt, flush_cnt}, 32'd0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      id_rs = tv[i].rs; id_rt = tv[i].rt; id_use_rs = tv[i].urs; id_use_rt = tv[i].urt;
      ex_memread = tv[i].mrd; ex_wen = tv[i].wen; ex_waddr = tv[i].wa;
      ex_branch_taken = tv[i].br; mem_req = tv[i].mreq; mem_ready = tv[i].mrdy;
      cnt_clr = tv[i].clr;
      #2;
      $display("vec %0d: st=%0d outs=%b stall=%0d flush=%0d", i, state,
               {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze},
               stall_cnt, flush_cnt);
      chk("outs", i, {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze},
          {26'd0, tv[i].exp_o});
      chk("state", i, {30'd0, state}, {30'd0, tv[i].st});
      chk("stall_cnt", i, {16'd0, stall_cnt}, {16'd0, tv[i].sc});
      chk("flush_cnt", i, {16'd0, flush_cnt}, {16'd0, tv[i].fc});
      tick();
    end

    // Asynchronous reset asserted in the middle of a memory wait.
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    chk("mw_state", 0, {30'd0, state}, 32'd1);
    rst = 1'b0;
    #1;
    $display("async reset: st=%0d frz=%0d pcw=%0d stall=%0d flush=%0d",
             state, pipe_freeze, pc_write, stall_cnt, flush_cnt);
    chk("arst_state", 0, {30'd0, state}, 32'd0);
    chk("arst_frz", 0, {31'd0, pipe_freeze}, 32'd0);
    chk("arst_pcw", 0, {31'd0, pc_write}, 32'd0);
    chk("arst_cnts", 0, {stall_cnt, flush_cnt}, 32'd0);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("post_rst_pcw", 0, {31'd0, pc_write}, 32'd1);
    tick();

    // Two-bit counters saturate at 3; clear beats a same-cycle increment.
    s_mreq = 1; s_mrdy = 0;
    for (int k = 0; k < 5; k++) tick();
    $display("sat: stall=%0d st=%0d", s_scnt, s_state);
    chk("sat_stall", 0, {30'd0, s_scnt}, 32'd3);
    s_clr = 1;
    tick();
    s_clr = 0;
    chk("clr_stall", 0, {30'd0, s_scnt}, 32'd0);
    s_mrdy = 1; s_mreq = 0;
    tick();
    s_mrdy = 0;

    // BR_FLUSH_CYC=1: single squash cycle, no BR_FLUSH state.
    s_br = 1;
    #1;
    chk("br1_outs", 0, {26'd0, s_pcw, s_ifw, s_iff, s_bub, s_idf, s_frz}, 32'b111010);
    tick();
    s_br = 0;
    #1;
    $display("br1: st=%0d iff=%0d flush=%0d", s_state, s_iff, s_fcnt);
    chk("br1_state", 0, {30'd0, s_state}, 32'd0);
    chk("br1_iff", 0, {31'd0, s_iff}, 32'd0);
    chk("br1_fcnt", 0, {30'd0, s_fcnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives write-enable, bubble and flush controls for the PC, IF/ID and ID/EXE stage registers, and a global freeze for data-memory wait states.
- Detects load-use hazards against the ID/EXE register's memread/waddr outputs and squashes wrong-path instructions after a taken branch resolved in EXE.
- Keeps saturating stall and flush counters for performance measurement.

Parameters:
- ASIZE, 5, register address width.
- BR_FLUSH_CYC, 2, cycles of IF/ID flush after a taken branch (legal range 1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 resets the block.
- id_rs  in  ASIZE  source register 1 of the instruction in ID.
- id_rt  in  ASIZE  source register 2 of the instruction in ID.
- id_use_rs  in  1  instruction in ID reads id_rs.
- id_use_rt  in  1  instruction in ID reads id_rt.
- ex_memread  in  1  memread output of the ID/EXE register.
- ex_wen  in  1  wen output of the ID/EXE register.
- ex_waddr  in  ASIZE  waddr output of the ID/EXE register.
- ex_branch_taken  in  1  branch in EXE resolved taken.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EXE control fields load 0 (load-use bubble).
- idex_flush  out  1  ID/EXE loads a NOP (branch squash).
- pipe_freeze  out  1  ID/EXE, EXE/MEM and MEM/WB registers hold.
- state  out  2  current state: RUN=0, MEM_WAIT=1, BR_FLUSH=2.
- stall_cnt  out  CNT_W  count of stalled cycles, saturating.
- flush_cnt  out  CNT_W  count of taken-branch events, saturating.

Behaviour:
- Registered elements: state, the flush down-counter, stall_cnt and flush_cnt. All other outputs are combinational (Mealy) from state and the inputs.
- While rst=0:
  - state=RUN, down-counter=0, stall_cnt=0, flush_cnt=0.
  - All 1-bit outputs are 0, including pc_write and ifid_write.
- Definitions:
  - memstall = mem_req & ~mem_ready.
  - loaduse = ex_memread & ex_wen & (ex_waddr!=0) & ((id_use_rs & id_rs==ex_waddr) | (id_use_rt & id_rt==ex_waddr)).
- Default outputs: pc_write=ifid_write=1; all other 1-bit outputs 0.
- RUN state, evaluated in priority order:
  1. memstall: pipe_freeze=1, pc_write=0, ifid_write=0. Next state MEM_WAIT.
  2. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. flush_cnt+1. If BR_FLUSH_CYC>1, load the down-counter with BR_FLUSH_CYC-1 and go to BR_FLUSH; otherwise stay in RUN.
  3. loaduse: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN. This gives exactly one bubble because the load leaves EXE on the next edge.
  4. Otherwise: default outputs.
- MEM_WAIT state:
  - mem_ready=0: pipe_freeze=1, pc_write=0, ifid_write=0. ex_branch_taken and loaduse are ignored (the EXE contents are held and are re-evaluated after release).
  - mem_ready=1: outputs and next state follow the RUN rules with memstall treated as 0.
- BR_FLUSH state:
  - ifid_flush=1, pc_write=1, ifid_write=1. loaduse and ex_branch_taken are ignored.
  - The down-counter decrements each cycle. When it equals 1, the next state is RUN.
  - memstall in this state: pipe_freeze=1, pc_write=0, ifid_write=0, ifid_flush=0. The down-counter holds and the state stays BR_FLUSH.
- stall_cnt increments on every cycle with pc_write=0 and rst=1.
- Both counters saturate at all-ones.
- cnt_clr=1 zeroes both counters at the next edge and overrides any increment in the same cycle.
- Reset asserted mid-stall or mid-flush returns the block to RUN immediately, without waiting for a clock edge.
- state encoding 3 is illegal; the next state from it is RUN.

Test Plan:
- lw writes r5 (ex_memread=1, ex_wen=1, ex_waddr=5), ID has id_rs=5 with id_use_rs=1 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; next cycle with ex_memread=0 -> normal flow.
- Same as above with ex_waddr=0, or with id_use_rs=0 -> no stall, stall_cnt stays 0.
- ex_branch_taken pulse, BR_FLUSH_CYC=2 -> cycle 0: ifid_flush=1 and idex_flush=1; cycle 1: state=BR_FLUSH, ifid_flush=1, idex_flush=0; cycle 2: state=RUN; flush_cnt=1.
- mem_req=1 with mem_ready held low for 3 cycles, then 1 -> pipe_freeze=1 for 3 cycles, state=MEM_WAIT; the release cycle has pc_write=1; stall_cnt=3.
- memstall in the first BR_FLUSH cycle, lasting 2 cycles -> freeze for 2 cycles with ifid_flush=0 and the down-counter held; then 1 flush cycle, then RUN.
- rst driven low mid-MEM_WAIT without a clock edge -> state=0, pipe_freeze=0, counters 0 immediately; preset stall_cnt to max then stall once -> stays at 0xFFFF; cnt_clr during a stall -> stall_cnt=0.
